// File: rtl/tmds_decoder.sv
`timescale 1ns/1ps
// TMDS single-channel decoder: hunts for the 10-bit word boundary using runs of control
// tokens, then decodes pixel data, DE and control bits with a fixed two-cycle latency.
module tmds_decoder #(
    parameter int unsigned C_lock_tokens   = 8,
    parameter int unsigned C_search_cycles = 2048,
    parameter int unsigned C_timeout       = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] i_sym,
    output logic [7:0] o_data,
    output logic [1:0] o_c,
    output logic       o_de,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int unsigned RunW   = $clog2(C_lock_tokens + 1);
    localparam int unsigned DwellW = $clog2(C_search_cycles);
    localparam int unsigned GapW   = $clog2(C_timeout + 1);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e            state_q, state_d;
    logic [3:0]        offset_q, offset_d;
    logic [9:0]        prev_q, q_q, aligned;
    logic [19:0]       win;
    logic [RunW-1:0]   run_q, run_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              flush_q, flush_d;
    logic              ctl, eff_locked, de_d;
    logic [1:0]        ctl_c, c_d;
    logic [7:0]        d, dec, data_d;

    assign win      = {i_sym, prev_q};
    assign aligned  = win[offset_q +: 10];
    assign o_offset = offset_q;

    always_comb begin
        ctl   = 1'b1;
        ctl_c = 2'b00;
        case (q_q)
            10'h354: ctl_c = 2'b00;
            10'h0AB: ctl_c = 2'b01;
            10'h154: ctl_c = 2'b10;
            10'h2AB: ctl_c = 2'b11;
            default: ctl   = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        dec    = '0;
        d      = q_q[9] ? ~q_q[7:0] : q_q[7:0];
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = q_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        run_d      = run_q;
        dwell_d    = dwell_q;
        gap_d      = gap_q;
        flush_d    = 1'b0;
        eff_locked = 1'b0;
        case (state_q)
            StSearch: begin
                dwell_d = dwell_q + 1'b1;
                // flush_q: q still carries a word aligned to the previous offset
                run_d   = (ctl && !flush_q) ? run_q + 1'b1 : '0;
                if (ctl && !flush_q && run_q == RunW'(C_lock_tokens - 1)) begin
                    state_d    = StLocked;
                    eff_locked = 1'b1;
                    run_d      = '0;
                    dwell_d    = '0;
                    gap_d      = '0;
                end else if (dwell_q == DwellW'(C_search_cycles - 1)) begin
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    run_d    = '0;
                    dwell_d  = '0;
                    flush_d  = 1'b1;
                end
            end
            StLocked: begin
                eff_locked = 1'b1;
                gap_d      = ctl ? '0 : gap_q + 1'b1;
                if (!ctl && gap_q == GapW'(C_timeout - 1)) begin
                    state_d    = StSearch;
                    eff_locked = 1'b0;
                    gap_d      = '0;
                    run_d      = '0;
                    dwell_d    = '0;
                end
            end
        endcase
        de_d   = eff_locked && !ctl;
        data_d = de_d ? dec : '0;
        c_d    = !eff_locked ? 2'b00 : (ctl ? ctl_c : o_c);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= StSearch;
            offset_q <= '0;
            prev_q   <= '0;
            q_q      <= '0;
            run_q    <= '0;
            dwell_q  <= '0;
            gap_q    <= '0;
            flush_q  <= 1'b0;
            o_data   <= '0;
            o_c      <= '0;
            o_de     <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            prev_q   <= i_sym;
            q_q      <= aligned;
            run_q    <= run_d;
            dwell_q  <= dwell_d;
            gap_q    <= gap_d;
            flush_q  <= flush_d;
            o_data   <= data_d;
            o_c      <= c_d;
            o_de     <= de_d;
            o_locked <= eff_locked;
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
`timescale 1ns/1ps
// Bench for tmds_decoder: serialises TMDS symbols at a chosen bit offset and checks alignment,
// lock, timeout and decoded outputs against a reference built from an encoder model.
module tb_tmds_decoder;

    localparam int MAXS        = 21000;
    localparam int LOCK_TOKENS = 8;
    localparam int SEARCH      = 2048;
    localparam int TIMEOUT     = 4096;
    localparam int LINE        = 1344;

    logic       clk_pixel = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] i_sym     = '0;
    logic [7:0] o_data;
    logic [1:0] o_c;
    logic       o_de;
    logic       o_locked;
    logic [3:0] o_offset;

    tmds_decoder #(
        .C_lock_tokens  (LOCK_TOKENS),
        .C_search_cycles(SEARCH),
        .C_timeout      (TIMEOUT)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .i_sym    (i_sym),
        .o_data   (o_data),
        .o_c      (o_c),
        .o_de     (o_de),
        .o_locked (o_locked),
        .o_offset (o_offset)
    );

    always #5 clk_pixel = ~clk_pixel;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] sym [MAXS];
    int         nsym = 0;
    int         kofs = 0;
    logic [7:0] dec_tab [1024];

    // DVI encoder stage 1: transition-minimised word q_m
    function automatic logic [8:0] enc_qm(input logic [7:0] v);
        logic [8:0] qm;
        logic       use_xnor;
        use_xnor = ($countones(v) > 4) || ($countones(v) == 4 && v[0] == 1'b0);
        qm[0] = v[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ v[i]) : (qm[i-1] ^ v[i]);
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    function automatic logic [9:0] enc_word(input logic [7:0] v, input logic inv);
        logic [8:0] qm;
        qm = enc_qm(v);
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction

    function automatic logic is_tok(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    function automatic logic [1:0] tok_c(input logic [9:0] w);
        case (w)
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [9:0] tok_word(input int i);
        case (i)
            1:       return 10'h0AB;
            2:       return 10'h154;
            3:       return 10'h2AB;
            default: return 10'h354;
        endcase
    endfunction

    // Input word n carries serial bits 10n..10n+9; symbol j starts at serial bit kofs+10j.
    function automatic logic [9:0] word_at(input int n);
        logic [9:0] r;
        int         p;
        int         idx;
        r = '0;
        for (int b = 0; b < 10; b++) begin
            p = 10 * n + b;
            if (p >= kofs) begin
                idx = (p - kofs) / 10;
                if (idx < nsym) r[b] = sym[idx][(p - kofs) % 10];
            end
        end
        return r;
    endfunction

    function automatic int predict_lock(input int j0);
        int run;
        run = 0;
        for (int j = j0; j < nsym; j++) begin
            run = is_tok(sym[j]) ? run + 1 : 0;
            if (run == LOCK_TOKENS) return j;
        end
        return -1;
    endfunction

    function automatic logic [9:0] sym_at(input int s);
        return (s >= 0 && s < nsym) ? sym[s] : 10'h000;
    endfunction

    // Packed as {locked, de, c[1:0], data[7:0]}
    function automatic logic [11:0] expect_beat(input logic [9:0] w, input logic lk,
                                                input logic [1:0] last_c);
        if (!lk) return 12'h000;
        if (is_tok(w)) return {1'b1, 1'b0, tok_c(w), 8'h00};
        return {1'b1, 1'b1, last_c, dec_tab[w]};
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        i_sym = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        i_sym = word_at(n);
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_reset();
        int          jl;
        logic [11:0] exp;
        logic [1:0]  exp_c;
        kofs = 0;
        nsym = 40;
        for (int j = 0; j < nsym; j++) sym[j] = 10'h354;
        reset_dut();
        n_cmp++;
        if ({o_locked, o_de, o_c, o_data, o_offset} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_state got %h want 0000", {o_locked, o_de, o_c, o_data, o_offset});
        end
        jl    = predict_lock(0);
        exp_c = 2'b00;
        for (int n = 0; n < 30; n++) begin
            step(n);
            exp   = expect_beat(sym_at(n - 2), (n - 2) >= jl, exp_c);
            exp_c = exp[9:8];
            n_cmp++;
            if ({o_locked, o_de, o_c, o_data} !== exp) begin
                n_bad++;
                $display("FAIL lock_offset0 n=%0d got %h want %h", n,
                         {o_locked, o_de, o_c, o_data}, exp);
            end
            n_cmp++;
            if (o_offset !== 4'd0) begin
                n_bad++;
                $display("FAIL lock_offset0_ofs n=%0d got %0d want 0", n, o_offset);
            end
        end
    endtask

    // Shared body for the offset-hunting scenarios: compares every beat and the offset.
    task automatic run_and_check(input string name, input int jl, input int nsteps);
        logic [11:0] exp;
        logic [1:0]  exp_c;
        int          exp_off;
        exp_c = 2'b00;
        for (int n = 0; n < nsteps; n++) begin
            step(n);
            exp     = expect_beat(sym_at(n - 2), jl >= 0 && (n - 2) >= jl, exp_c);
            exp_c   = exp[9:8];
            exp_off = (jl >= 0 && (n - 2) >= jl) ? kofs : ((n + 1) / SEARCH) % 10;
            n_cmp++;
            if ({o_locked, o_de, o_c, o_data} !== exp) begin
                n_bad++;
                $display("FAIL %s n=%0d got %h want %h", name, n,
                         {o_locked, o_de, o_c, o_data}, exp);
            end
            n_cmp++;
            if (o_offset !== 4'(exp_off)) begin
                n_bad++;
                $display("FAIL %s_ofs n=%0d got %0d want %0d", name, n, o_offset, exp_off);
            end
        end
    endtask

    task automatic test_shifted_line();
        int jl;
        kofs = 7;
        nsym = 17000;
        for (int j = 0; j < nsym; j++) begin
            sym[j] = ((j % LINE) < 1024) ? enc_word(8'((j % LINE) % 256), 1'($urandom_range(0, 1)))
                                         : 10'h154;
        end
        reset_dut();
        jl = predict_lock(kofs * SEARCH - 1);
        run_and_check("shifted_line", jl, jl + LINE + 8);
    endtask

    task automatic test_decode_all();
        int          jl;
        int          p;
        int          lit_idx [3];
        logic [7:0]  lit_val [3];
        kofs = $urandom_range(1, 3);
        p    = kofs * SEARCH + 20;
        nsym = 0;
        for (int j = 0; j < p; j++) begin
            sym[nsym] = 10'h354;
            nsym++;
        end
        for (int v = 0; v < 256; v++) begin
            for (int inv = 0; inv < 2; inv++) begin
                sym[nsym] = enc_word(8'(v), 1'(inv));
                nsym++;
                if ($urandom_range(0, 6) == 0) begin
                    sym[nsym] = tok_word($urandom_range(0, 3));
                    nsym++;
                end
            end
        end
        lit_val[0] = 8'h00;
        lit_val[1] = 8'h00;
        lit_val[2] = 8'hFE;
        sym[nsym] = 10'h100; lit_idx[0] = nsym; nsym++;
        sym[nsym] = 10'h3FF; lit_idx[1] = nsym; nsym++;
        sym[nsym] = 10'h2FF; lit_idx[2] = nsym; nsym++;
        for (int j = 0; j < 12; j++) begin
            sym[nsym] = tok_word($urandom_range(0, 3));
            nsym++;
        end
        reset_dut();
        jl = predict_lock(kofs * SEARCH - 1);
        for (int n = 0; n < nsym; n++) begin
            step(n);
            for (int i = 0; i < 3; i++) begin
                if (n - 2 == lit_idx[i]) begin
                    n_cmp++;
                    if (o_data !== lit_val[i] || o_de !== 1'b1) begin
                        n_bad++;
                        $display("FAIL literal_%0d got de=%b data=%h want de=1 data=%h",
                                 i, o_de, o_data, lit_val[i]);
                    end
                end
            end
        end
        reset_dut();
        run_and_check("decode_all", jl, nsym);
    endtask

    task automatic test_timeout();
        int          jl;
        int          jl2;
        int          t;
        logic [11:0] exp;
        logic [1:0]  exp_c;
        logic        lk;
        kofs = 0;
        t    = 30;
        nsym = 0;
        for (int j = 0; j < t; j++) begin
            sym[nsym] = (j < 10) ? 10'h354 : tok_word($urandom_range(0, 3));
            nsym++;
        end
        for (int j = 0; j < TIMEOUT; j++) begin
            sym[nsym] = enc_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            nsym++;
        end
        for (int j = 0; j < 30; j++) begin
            sym[nsym] = 10'h0AB;
            nsym++;
        end
        reset_dut();
        jl    = predict_lock(0);
        jl2   = predict_lock(t + TIMEOUT);
        exp_c = 2'b00;
        for (int n = 0; n < nsym; n++) begin
            step(n);
            lk    = ((n - 2) >= jl && (n - 2) < t + TIMEOUT - 1) || ((n - 2) >= jl2);
            exp   = expect_beat(sym_at(n - 2), lk, exp_c);
            exp_c = exp[9:8];
            n_cmp++;
            if ({o_locked, o_de, o_c, o_data} !== exp) begin
                n_bad++;
                $display("FAIL timeout n=%0d got %h want %h", n, {o_locked, o_de, o_c, o_data}, exp);
            end
            n_cmp++;
            if (o_offset !== 4'd0) begin
                n_bad++;
                $display("FAIL timeout_ofs n=%0d got %0d want 0", n, o_offset);
            end
        end
    endtask

    task automatic test_no_lock_wrap();
        kofs = $urandom_range(0, 9);
        nsym = 10 * SEARCH + 80;
        for (int j = 0; j < nsym; j++) begin
            sym[j] = ((j % 12) < 7) ? 10'h354
                                    : enc_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        reset_dut();
        run_and_check("no_lock_wrap", -1, 10 * SEARCH + 64);
    endtask

    task automatic test_reset_midline();
        int jl;
        int p;
        kofs = $urandom_range(1, 2);
        p    = kofs * SEARCH + 20;
        nsym = 0;
        for (int j = 0; j < p + 300; j++) begin
            sym[nsym] = (j < p) ? 10'h354
                                : enc_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            nsym++;
        end
        reset_dut();
        jl = predict_lock(kofs * SEARCH - 1);
        run_and_check("pre_reset", jl, jl + 40);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({o_locked, o_de, o_c, o_data, o_offset} !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_reset got %h want 0000", {o_locked, o_de, o_c, o_data, o_offset});
        end
        reset_dut();
        run_and_check("relock_after_reset", jl, jl + 40);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < 1024; w++) dec_tab[w] = 8'h00;
        for (int v = 0; v < 256; v++) begin
            dec_tab[enc_word(8'(v), 1'b0)] = 8'(v);
            dec_tab[enc_word(8'(v), 1'b1)] = 8'(v);
        end
        test_reset();
        test_shifted_line();
        test_decode_all();
        test_timeout();
        test_no_lock_wrap();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
